obi_demux_1_to_n: RTL

//  Parametrised OBI 1-to-N demux: one OBI controller fans out to N_PORTS OBI slaves by address window.

---
 rtl/obi_demux_1_to_n_pkg.sv | 16 +
 rtl/obi_demux_1_to_n_resp_tracker.sv | 44 ++++
 rtl/obi_demux_1_to_n.sv | 124 ++++++++++++
 3 files changed

// File: rtl/obi_demux_1_to_n_pkg.sv
// Shared widths and constants for the OBI 1-to-N demux and its response tracker.
package obi_demux_1_to_n_pkg;

  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;
  localparam logic [31:0] OBI_ERR_RDATA = 32'hDEAD_BEEF;

  // Width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned obi_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/obi_demux_1_to_n_resp_tracker.sv
// Outstanding-transaction bookkeeping: count, current target, error responder, stall.
module obi_demux_1_to_n_resp_tracker #(
  parameter int unsigned SEL_W           = 3,
  parameter int unsigned CNT_W           = 3,
  parameter int unsigned N_PORTS         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             acc,
  input  logic             rsp,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] cnt,
  output logic [SEL_W-1:0] cur_sel,
  output logic             err_pend,
  output logic             stall
);

  localparam logic [SEL_W-1:0] SEL_ERR = SEL_W'(N_PORTS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt      <= '0;
      cur_sel  <= '0;
      err_pend <= 1'b0;
    end else begin
      if (acc && !rsp) begin
        cnt <= cnt + 1'b1;
      end else if (rsp && !acc) begin
        cnt <= cnt - 1'b1;
      end
      if (acc) begin
        cur_sel <= sel;
      end
      // Error responder answers every accepted unmapped access exactly one cycle later.
      err_pend <= acc && (sel == SEL_ERR);
    end
  end

  // A new target must wait for the old one to drain so responses stay in order.
  assign stall = (cnt == CNT_MAX) || ((cnt != '0) && (sel != cur_sel));

endmodule

// File: rtl/obi_demux_1_to_n.sv
// OBI 1-to-N demux: address-window decode to N slave ports plus an internal error responder.
module obi_demux_1_to_n
  import obi_demux_1_to_n_pkg::*;
#(
  parameter int unsigned                  N_PORTS         = 4,
  parameter int unsigned                  ADDR_W          = OBI_ADDR_W,
  parameter int unsigned                  DATA_W          = OBI_DATA_W,
  parameter logic [N_PORTS*ADDR_W-1:0]    BASE_ADDRS      = {N_PORTS{32'h0}},
  parameter logic [N_PORTS*ADDR_W-1:0]    END_ADDRS       = {N_PORTS{32'hFFF}},
  parameter int unsigned                  MAX_OUTSTANDING = 4,
  parameter bit                           WR_RESP         = 1'b1,
  parameter logic [DATA_W-1:0]            ERR_RDATA       = OBI_ERR_RDATA
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            ctrl_req_i,
  output logic                            ctrl_gnt_o,
  input  logic [ADDR_W-1:0]               ctrl_addr_i,
  input  logic                            ctrl_we_i,
  input  logic [DATA_W/8-1:0]             ctrl_be_i,
  input  logic [DATA_W-1:0]               ctrl_wdata_i,
  output logic                            ctrl_rvalid_o,
  output logic [DATA_W-1:0]               ctrl_rdata_o,
  output logic                            ctrl_err_o,
  output logic [N_PORTS-1:0]              port_req_o,
  input  logic [N_PORTS-1:0]              port_gnt_i,
  output logic [N_PORTS*ADDR_W-1:0]       port_addr_o,
  output logic [N_PORTS-1:0]              port_we_o,
  output logic [N_PORTS*(DATA_W/8)-1:0]   port_be_o,
  output logic [N_PORTS*DATA_W-1:0]       port_wdata_o,
  input  logic [N_PORTS-1:0]              port_rvalid_i,
  input  logic [N_PORTS*DATA_W-1:0]       port_rdata_i,
  output logic                            illegal_access_o
);

  localparam int unsigned      SEL_W   = obi_clog2(N_PORTS + 1);
  localparam int unsigned      CNT_W   = obi_clog2(MAX_OUTSTANDING + 1);
  localparam logic [SEL_W-1:0] SEL_ERR = SEL_W'(N_PORTS);

  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] cur_sel;
  logic [CNT_W-1:0] cnt;
  logic             err_pend;
  logic             stall;
  logic             dec_hit;
  logic             sel_gnt;
  logic             acc;
  logic             rsp;

  // Lowest matching window wins; no match selects the error responder.
  always_comb begin
    sel     = SEL_ERR;
    dec_hit = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!dec_hit && (ctrl_addr_i >= BASE_ADDRS[i*ADDR_W +: ADDR_W])
                   && (ctrl_addr_i <= END_ADDRS[i*ADDR_W +: ADDR_W])) begin
        sel     = SEL_W'(i);
        dec_hit = 1'b1;
      end
    end
  end

  // req/gnt: a transfer happens on a cycle with req && gnt; the controller holds its
  // request stable until granted, and stall only rises after an accept, so a slave
  // request once raised is never withdrawn before its grant.
  always_comb begin
    sel_gnt    = (sel == SEL_ERR);
    port_req_o = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_gnt       = port_gnt_i[i];
        port_req_o[i] = ctrl_req_i && !stall;
      end
    end
  end

  assign ctrl_gnt_o       = !stall && sel_gnt;
  assign illegal_access_o = ctrl_req_i && (sel == SEL_ERR);
  assign acc              = ctrl_req_i && ctrl_gnt_o && (!ctrl_we_i || WR_RESP);
  assign rsp              = ctrl_rvalid_o;

  always_comb begin
    ctrl_rvalid_o = 1'b0;
    ctrl_rdata_o  = '0;
    ctrl_err_o    = 1'b0;
    if (cnt != '0) begin
      if (cur_sel == SEL_ERR) begin
        ctrl_rvalid_o = err_pend;
        ctrl_rdata_o  = ERR_RDATA;
        ctrl_err_o    = err_pend;
      end else begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
          if (cur_sel == SEL_W'(i)) begin
            ctrl_rvalid_o = port_rvalid_i[i];
            ctrl_rdata_o  = port_rdata_i[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign port_addr_o  = {N_PORTS{ctrl_addr_i}};
  assign port_we_o    = {N_PORTS{ctrl_we_i}};
  assign port_be_o    = {N_PORTS{ctrl_be_i}};
  assign port_wdata_o = {N_PORTS{ctrl_wdata_i}};

  obi_demux_1_to_n_resp_tracker #(
    .SEL_W           (SEL_W),
    .CNT_W           (CNT_W),
    .N_PORTS         (N_PORTS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_tracker (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .acc      (acc),
    .rsp      (rsp),
    .sel      (sel),
    .cnt      (cnt),
    .cur_sel  (cur_sel),
    .err_pend (err_pend),
    .stall    (stall)
  );

endmodule
